// File: rtl/trap_controller.sv
// Machine-mode trap entry / mret sequencer: stalls the core and drives the single CSR write port,
// then redirects the PC. Define TRAP_VECTORED_EN to vector interrupts by cause when mtvec[1:0]==2'b01.
module trap_controller #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exception,
  input  logic              interrup,
  input  logic [XLEN-1:0]   excep_info,
  input  logic [XLEN-1:0]   pc_current,
  input  logic [XLEN-1:0]   instr,
  input  logic [ADDR_W-1:0] addr_rom,
  input  logic [ADDR_W-1:0] addr_ram,
  input  logic              mret,
  input  logic [XLEN-1:0]   mstatus,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  output logic              stall,
  output logic              csr_we,
  output logic [11:0]       csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              pc_redirect,
  output logic [XLEN-1:0]   pc_target,
  output logic              trap_active
);

  typedef enum logic [2:0] {
    IDLE, W_STATUS, W_EPC, W_CAUSE, W_TVAL, REDIR, R_STATUS, R_REDIR
  } state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  state_t            state_q;
  logic [XLEN-1:0]   pc_q, info_q, tval_q;
  logic              stall_q, csr_we_q, pc_redirect_q, trap_active_q;
  logic [11:0]       csr_addr_q;
  logic [XLEN-1:0]   csr_wdata_q, pc_target_q;

  logic [XLEN-1:0]   tval_d, status_trap, status_mret, tvec_base, trap_target;
  logic              accept_trap;

  assign accept_trap = exception | (interrup & mstatus[3]);

  always_comb begin
    tval_d = '0;
    case (excep_info[3:0])
      4'd0, 4'd1:             tval_d = {{(XLEN-ADDR_W){1'b0}}, addr_rom};
      4'd2:                   tval_d = instr;
      4'd4, 4'd5, 4'd6, 4'd7: tval_d = {{(XLEN-ADDR_W){1'b0}}, addr_ram};
      default:                tval_d = '0;
    endcase
  end

  // Trap: MPIE<=MIE, MIE<=0, MPP<=M. Return: MIE<=MPIE, MPIE<=1.
  always_comb begin
    status_trap     = mstatus;
    status_trap[7]  = mstatus[3];
    status_trap[3]  = 1'b0;
    status_trap[12:11] = 2'b11;
    status_mret     = mstatus;
    status_mret[3]  = mstatus[7];
    status_mret[7]  = 1'b1;
  end

  assign tvec_base = {mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign trap_target = (mtvec[1:0] == 2'b01 && info_q[XLEN-1])
                     ? tvec_base + {{(XLEN-6){1'b0}}, info_q[3:0], 2'b00}
                     : tvec_base;
`else
  logic unused_mode;
  assign unused_mode = ^mtvec[1:0];
  assign trap_target = tvec_base;
`endif

  // Outputs are registered for the state being entered, so they are valid throughout that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      info_q        <= '0;
      tval_q        <= '0;
      stall_q       <= 1'b0;
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= '0;
      trap_active_q <= 1'b0;
    end else begin
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= '0;
      case (state_q)
        IDLE: begin
          if (accept_trap) begin
            pc_q        <= pc_current;
            info_q      <= excep_info;
            tval_q      <= tval_d;
            state_q     <= W_STATUS;
            stall_q     <= 1'b1;
            csr_we_q    <= 1'b1;
            csr_addr_q  <= A_MSTATUS;
            csr_wdata_q <= status_trap;
          end else if (mret) begin
            state_q     <= R_STATUS;
            stall_q     <= 1'b1;
            csr_we_q    <= 1'b1;
            csr_addr_q  <= A_MSTATUS;
            csr_wdata_q <= status_mret;
          end
        end
        W_STATUS: begin
          state_q     <= W_EPC;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= A_MEPC;
          csr_wdata_q <= pc_q;
        end
        W_EPC: begin
          state_q     <= W_CAUSE;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= A_MCAUSE;
          csr_wdata_q <= info_q;
        end
        W_CAUSE: begin
          state_q     <= W_TVAL;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= A_MTVAL;
          csr_wdata_q <= tval_q;
        end
        W_TVAL: begin
          state_q       <= REDIR;
          pc_redirect_q <= 1'b1;
          pc_target_q   <= trap_target;
          trap_active_q <= 1'b1;
        end
        R_STATUS: begin
          state_q       <= R_REDIR;
          pc_redirect_q <= 1'b1;
          pc_target_q   <= mepc;
          trap_active_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall       = stall_q;
  assign csr_we      = csr_we_q;
  assign csr_addr    = csr_addr_q;
  assign csr_wdata   = csr_wdata_q;
  assign pc_redirect = pc_redirect_q;
  assign pc_target   = pc_target_q;
  assign trap_active = trap_active_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: vector table of trap requests plus hand-built sequences
// for mret, busy-time pulses and reset abort.
module tb_trap_controller;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        exception = 1'b0, interrup = 1'b0, mret = 1'b0;
  logic [31:0] excep_info = '0, pc_current = '0, instr = '0;
  logic [15:0] addr_rom = '0, addr_ram = '0;
  logic [31:0] mstatus = '0, mtvec = '0, mepc = '0;
  logic        stall, csr_we, pc_redirect, trap_active;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, pc_target;

  trap_controller #(.XLEN(32), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .exception(exception), .interrup(interrup),
    .excep_info(excep_info), .pc_current(pc_current), .instr(instr),
    .addr_rom(addr_rom), .addr_ram(addr_ram), .mret(mret), .mstatus(mstatus),
    .mtvec(mtvec), .mepc(mepc), .stall(stall), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .trap_active(trap_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc, intr, mr;
    logic [31:0] info, pc, ins;
    logic [15:0] arom, aram;
    logic [31:0] mst, tvec;
    logic        acc;
    logic [31:0] e_status, e_tval, e_target;
  } vec_t;

  vec_t vecs[6];
  int   tests = 0, fails = 0;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] IRQ_TARGET = 32'h0000_012C;
`else
  localparam logic [31:0] IRQ_TARGET = 32'h0000_0100;
`endif

  function automatic vec_t mk(input logic exc, intr, mr, input logic [31:0] info, pc, ins,
                              input logic [15:0] arom, aram, input logic [31:0] mst, tvec,
                              input logic acc, input logic [31:0] e_status, e_tval, e_target);
    vec_t v;
    v.exc = exc; v.intr = intr; v.mr = mr; v.info = info; v.pc = pc; v.ins = ins;
    v.arom = arom; v.aram = aram; v.mst = mst; v.tvec = tvec; v.acc = acc;
    v.e_status = e_status; v.e_tval = e_tval; v.e_target = e_target;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_write(input string name, input logic [11:0] a, input logic [31:0] d);
    chk({name, " we"}, {31'b0, csr_we}, 32'd1);
    chk({name, " addr"}, {20'b0, csr_addr}, {20'b0, a});
    chk({name, " data"}, csr_wdata, d);
    chk({name, " stall"}, {31'b0, stall}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string n;
    n = $sformatf("v%0d", idx);
    @(negedge clk);
    exception = v.exc; interrup = v.intr; mret = v.mr; excep_info = v.info;
    pc_current = v.pc; instr = v.ins; addr_rom = v.arom; addr_ram = v.aram;
    mstatus = v.mst; mtvec = v.tvec;
    @(negedge clk);
    exception = 1'b0; interrup = 1'b0; mret = 1'b0;
    if (v.acc) begin
      chk_write({n, " mstatus"}, 12'h300, v.e_status);
      @(negedge clk); chk_write({n, " mepc"}, 12'h341, v.pc);
      @(negedge clk); chk_write({n, " mcause"}, 12'h342, v.info);
      @(negedge clk); chk_write({n, " mtval"}, 12'h343, v.e_tval);
      @(negedge clk);
      chk({n, " redir"}, {31'b0, pc_redirect}, 32'd1);
      chk({n, " target"}, pc_target, v.e_target);
      chk({n, " redir we"}, {31'b0, csr_we}, 32'd0);
      chk({n, " redir addr"}, {20'b0, csr_addr}, 32'd0);
      chk({n, " redir stall"}, {31'b0, stall}, 32'd1);
      chk({n, " trap_active"}, {31'b0, trap_active}, 32'd1);
      @(negedge clk);
      chk({n, " stall end"}, {31'b0, stall}, 32'd0);
      chk({n, " redir end"}, {31'b0, pc_redirect}, 32'd0);
    end else begin
      repeat (2) begin
        chk({n, " ignored stall"}, {31'b0, stall}, 32'd0);
        chk({n, " ignored we"}, {31'b0, csr_we}, 32'd0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int we_cnt;
    //            exc  irq  mret info          pc      instr         arom     aram     mstatus tvec    acc  status  tval          target
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 32'h2,        32'h08, 32'h007002FF, 16'h0,   16'h0,   32'h8,  32'h100, 1'b1, 32'h1880, 32'h007002FF, 32'h100);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, 32'h5,        32'h20, 32'h0,        16'h1234, 16'hF000, 32'h0, 32'h100, 1'b1, 32'h1800, 32'h0000F000, 32'h100);
    vecs[2] = mk(1'b0, 1'b1, 1'b0, 32'h8000000B, 32'h30, 32'h0,        16'h0,   16'h0,   32'h0,  32'h101, 1'b0, 32'h0,    32'h0,        32'h0);
    vecs[3] = mk(1'b0, 1'b1, 1'b0, 32'h8000000B, 32'h30, 32'h0,        16'h0,   16'h0,   32'h8,  32'h101, 1'b1, 32'h1880, 32'h0,        IRQ_TARGET);
    vecs[4] = mk(1'b1, 1'b0, 1'b0, 32'h1,        32'h40, 32'h0,        16'hABCD, 16'h5555, 32'h80, 32'h201, 1'b1, 32'h1800, 32'h0000ABCD, 32'h200);
    vecs[5] = mk(1'b1, 1'b1, 1'b1, 32'h2,        32'h08, 32'h00000013, 16'h0,   16'h0,   32'h8,  32'h100, 1'b1, 32'h1880, 32'h00000013, 32'h100);

    repeat (2) @(negedge clk);
    chk("reset stall", {31'b0, stall}, 32'd0);
    chk("reset we", {31'b0, csr_we}, 32'd0);
    chk("reset redir", {31'b0, pc_redirect}, 32'd0);
    chk("reset trap_active", {31'b0, trap_active}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // mret after the simultaneous-request trap: restore MIE from MPIE, return to mepc
    @(negedge clk);
    mstatus = 32'h1880; mepc = 32'h08; mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    chk_write("mret mstatus", 12'h300, 32'h1888);
    @(negedge clk);
    chk("mret redir", {31'b0, pc_redirect}, 32'd1);
    chk("mret target", pc_target, 32'h08);
    chk("mret trap_active", {31'b0, trap_active}, 32'd0);
    chk("mret stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    chk("mret stall end", {31'b0, stall}, 32'd0);

    // exception pulse while busy in W_CAUSE must not queue or restart
    mstatus = 32'h8; mtvec = 32'h100;
    @(negedge clk);
    exception = 1'b1; excep_info = 32'h2; pc_current = 32'h50; instr = 32'h1;
    we_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exception = 1'b0;
      if (csr_we) we_cnt++;
      if (csr_we && csr_addr == 12'h342) begin
        exception = 1'b1; excep_info = 32'h5; pc_current = 32'h99;
      end
    end
    chk("busy csr_we count", we_cnt, 32'd4);
    chk("busy stall end", {31'b0, stall}, 32'd0);

    // reset in the middle of W_EPC aborts the sequence
    @(negedge clk);
    exception = 1'b1; excep_info = 32'h2; pc_current = 32'h60;
    @(negedge clk);
    exception = 1'b0;
    @(negedge clk);
    chk("pre-reset in W_EPC", {20'b0, csr_addr}, 32'h341);
    rst_n = 1'b0;
    #1;
    chk("async rst stall", {31'b0, stall}, 32'd0);
    chk("async rst we", {31'b0, csr_we}, 32'd0);
    chk("async rst addr", {20'b0, csr_addr}, 32'd0);
    chk("async rst data", csr_wdata, 32'd0);
    chk("async rst trap_active", {31'b0, trap_active}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    we_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (csr_we || pc_redirect || stall) we_cnt++;
    end
    chk("post-reset activity", we_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
